// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential BCD conversion service.
package bcd_pkg;

    localparam int BIN_W   = 10;
    localparam int DIGIT_W = 4;
    localparam int MAX_DEC = 999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_serial.sv
// Iterative double-dabble core: one operand bit per clock, MSB first.
// The digit outputs expose the post-iteration value so a consumer can
// register the final digits on the same edge as the last iteration.
module bcd_serial
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIN_W-1:0]   operand,
    output logic               done,
    output logic [DIGIT_W-1:0] hundreds,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones
);

    localparam int SCR_W = 3 * DIGIT_W + BIN_W;

    logic [BIN_W-1:0]   sh_q;
    logic [DIGIT_W-1:0] h_q;
    logic [DIGIT_W-1:0] t_q;
    logic [DIGIT_W-1:0] o_q;
    logic [3:0]         cnt_q;
    logic               run_q;
    logic [SCR_W-1:0]   scr_n;

    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
    endfunction

    // One shift-add-3 step over {hundreds, tens, ones, operand}
    always_comb begin
        scr_n = {add3(h_q), add3(t_q), add3(o_q), sh_q} << 1;
    end

    assign hundreds = scr_n[SCR_W-1 -: DIGIT_W];
    assign tens     = scr_n[SCR_W-DIGIT_W-1 -: DIGIT_W];
    assign ones     = scr_n[SCR_W-2*DIGIT_W-1 -: DIGIT_W];
    assign done     = run_q && (cnt_q == 4'(BIN_W - 1));

    // Scratch registers and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            h_q   <= '0;
            t_q   <= '0;
            o_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            sh_q  <= operand;
            h_q   <= '0;
            t_q   <= '0;
            o_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            {h_q, t_q, o_q, sh_q} <= scr_n;
            cnt_q <= cnt_q + 4'd1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shared binary-to-BCD converter: arbitration, operand capture,
// saturation above MAX_DEC and held result registers around bcd_serial.
module bcd_convert_arbiter
    import bcd_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BIN_W-1:0]   bin,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    valid,
    output logic [DIGIT_W-1:0]      hundreds,
    output logic [DIGIT_W-1:0]      tens,
    output logic [DIGIT_W-1:0]      ones,
    output logic                    ovf
);

    localparam int IDW = $clog2(NREQ);

    state_t             state_q;
    state_t             state_n;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     gsel;
    logic               found;
    logic [BIN_W-1:0]   opnd_mux;
    logic [BIN_W-1:0]   opnd_q;
    logic               start;
    logic               core_done;
    logic [DIGIT_W-1:0] core_h;
    logic [DIGIT_W-1:0] core_t;
    logic [DIGIT_W-1:0] core_o;

    // First requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                gsel  = IDW'(idx);
            end
        end
    end

    assign opnd_mux = bin[32'(gsel) * BIN_W +: BIN_W];
    assign start    = (state_q == IDLE) && found;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_n = state_q;
        busy    = 1'b0;
        valid   = 1'b0;
        ack     = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (core_done) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                valid         = 1'b1;
                ack[grant_id] = 1'b1;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Grant capture, result registers and round-robin pointer.
    // Results load on the final-iteration edge so they are already visible in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            grant_id <= '0;
            opnd_q   <= '0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
            ovf      <= 1'b0;
        end else begin
            if (start) begin
                opnd_q   <= opnd_mux;
                grant_id <= gsel;
            end
            if ((state_q == SHIFT) && core_done) begin
                if (opnd_q > BIN_W'(MAX_DEC)) begin
                    hundreds <= DIGIT_W'(9);
                    tens     <= DIGIT_W'(9);
                    ones     <= DIGIT_W'(9);
                    ovf      <= 1'b1;
                end else begin
                    hundreds <= core_h;
                    tens     <= core_t;
                    ones     <= core_o;
                    ovf      <= 1'b0;
                end
            end
            if (state_q == DONE) begin
                rr_ptr_q <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    bcd_serial u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .operand  (opnd_mux),
        .done     (core_done),
        .hundreds (core_h),
        .tens     (core_t),
        .ones     (core_o)
    );

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter: directed table, multi-cycle
// corner sequences and a randomized run against an arithmetic reference model.
module tb_bcd_convert_arbiter;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*10-1:0]   bin;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 valid;
    logic [3:0]           hundreds;
    logic [3:0]           tens;
    logic [3:0]           ones;
    logic                 ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_convert_arbiter #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bin      (bin),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .valid    (valid),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .ovf      (ovf)
    );

    typedef struct {
        int bin;
        int h;
        int t;
        int o;
        int ovf;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void ref_digits(input int v, output int h, output int t,
                                       output int o, output int f);
        if (v > 999) begin
            h = 9; t = 9; o = 9; f = 1;
        end else begin
            h = v / 100; t = (v / 10) % 10; o = v % 10; f = 0;
        end
    endfunction

    task automatic set_bin(input int id, input int v);
        bin[10*id +: 10] = 10'(v);
    endtask

    task automatic wait_valid(input int budget, input bit chk_busy, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            if (chk_busy) chk("busy_during_conversion", int'(busy), 1);
            if (valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout actual=none required=valid within %0d cycles", budget);
        end
    endtask

    task automatic check_result(input string tag, input int id, input int v);
        int h, t, o, f;
        ref_digits(v, h, t, o, f);
        chk({tag, "_valid"},    int'(valid),    1);
        chk({tag, "_ack"},      int'(ack),      1 << id);
        chk({tag, "_grant_id"}, int'(grant_id), id);
        chk({tag, "_hundreds"}, int'(hundreds), h);
        chk({tag, "_tens"},     int'(tens),     t);
        chk({tag, "_ones"},     int'(ones),     o);
        chk({tag, "_ovf"},      int'(ovf),      f);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     int'(busy),     0);
        chk({tag, "_valid"},    int'(valid),    0);
        chk({tag, "_ack"},      int'(ack),      0);
        chk({tag, "_grant_id"}, int'(grant_id), 0);
        chk({tag, "_hundreds"}, int'(hundreds), 0);
        chk({tag, "_tens"},     int'(tens),     0);
        chk({tag, "_ones"},     int'(ones),     0);
        chk({tag, "_ovf"},      int'(ovf),      0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int ptr, next_free, exp_cycle, exp_id, exp_val;
        int mbin[NREQ];
        logic [NREQ-1:0] pend;

        tv[0] = '{255,  2, 5, 5, 0};
        tv[1] = '{0,    0, 0, 0, 0};
        tv[2] = '{999,  9, 9, 9, 0};
        tv[3] = '{1000, 9, 9, 9, 1};
        tv[4] = '{1023, 9, 9, 9, 1};
        tv[5] = '{1,    0, 0, 1, 0};
        tv[6] = '{100,  1, 0, 0, 0};
        tv[7] = '{580,  5, 8, 0, 0};

        rst = 1'b1;
        req = '0;
        bin = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed table: single requests, one at a time, rotating requester index
        for (int i = 0; i < 8; i++) begin
            int id;
            id = i % NREQ;
            set_bin(id, tv[i].bin);
            req = NREQ'(1 << id);
            wait_valid(20, i == 0, lat);
            chk("tbl_latency",  lat,            11);
            chk("tbl_ack",      int'(ack),      1 << id);
            chk("tbl_grant_id", int'(grant_id), id);
            chk("tbl_hundreds", int'(hundreds), tv[i].h);
            chk("tbl_tens",     int'(tens),     tv[i].t);
            chk("tbl_ones",     int'(ones),     tv[i].o);
            chk("tbl_ovf",      int'(ovf),      tv[i].ovf);
            req = '0;
            @(negedge clk);
            chk("tbl_valid_drop", int'(valid), 0);
            chk("tbl_ack_drop",   int'(ack),   0);
            chk("tbl_hold_ones",  int'(ones),  tv[i].o);
        end

        // Round robin with all requests held
        do_reset();
        for (int i = 0; i < NREQ; i++) set_bin(i, i + 1);
        req = '1;
        for (int n = 0; n < 5; n++) begin
            wait_valid(20, 1'b0, lat);
            chk("rr_spacing", lat, (n == 0) ? 11 : 12);
            check_result("rr", n % NREQ, (n % NREQ) + 1);
        end
        req = '0;
        @(negedge clk);

        // Priority rotation: serve 2, then 1 and 3 arrive during SHIFT
        set_bin(2, 7);
        req = 4'b0100;
        repeat (3) @(negedge clk);
        set_bin(1, 8);
        set_bin(3, 9);
        req = 4'b1110;
        wait_valid(20, 1'b0, lat);
        check_result("prio_first", 2, 7);
        req = 4'b1010;
        wait_valid(20, 1'b0, lat);
        chk("prio_spacing", lat, 12);
        check_result("prio_second", 3, 9);
        req = 4'b0010;
        wait_valid(20, 1'b0, lat);
        check_result("prio_third", 1, 8);
        req = '0;
        @(negedge clk);

        // Operand capture: bin changes after the grant must not matter
        set_bin(0, 321);
        req = 4'b0001;
        repeat (2) @(negedge clk);
        set_bin(0, 42);
        wait_valid(20, 1'b0, lat);
        check_result("capture", 0, 321);
        req = '0;
        @(negedge clk);

        // Reset on the 5th SHIFT cycle aborts the conversion
        set_bin(0, 500);
        set_bin(1, 77);
        req = 4'b0001;
        repeat (5) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        set_bin(3, 5);
        req = 4'b1010;
        wait_valid(20, 1'b0, lat);
        chk("abort_next_latency", lat, 11);
        check_result("abort_next", 1, 77);
        req = 4'b1000;
        wait_valid(20, 1'b0, lat);
        chk("abort_after_spacing", lat, 12);
        check_result("abort_after", 3, 5);
        req = '0;
        @(negedge clk);

        // Randomized traffic against a cycle-level arithmetic model of the service
        do_reset();
        ptr       = 0;
        next_free = 0;
        exp_cycle = -1;
        exp_id    = 0;
        exp_val   = 0;
        pend      = '0;
        for (int i = 0; i < NREQ; i++) mbin[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c == exp_cycle) begin
                check_result("rnd", exp_id, exp_val);
                pend[exp_id] = 1'b0;
            end else begin
                chk("rnd_valid_idle", int'(valid), 0);
                chk("rnd_ack_idle",   int'(ack),   0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        mbin[i] = int'($urandom_range(0, 1023));
                        set_bin(i, mbin[i]);
                        pend[i] = 1'b1;
                    end
                end else if (i == exp_id && c < exp_cycle && $urandom_range(0, 3) == 0) begin
                    set_bin(i, int'($urandom_range(0, 1023)));
                end
            end
            req = pend;
            if (c + 1 >= next_free && pend != '0) begin
                bit got;
                got = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    int k;
                    k = (ptr + j) % NREQ;
                    if (!got && pend[k]) begin
                        got    = 1'b1;
                        exp_id = k;
                    end
                end
                exp_val   = mbin[exp_id];
                exp_cycle = c + 11;
                next_free = c + 13;
                ptr       = (exp_id + 1) % NREQ;
            end
            @(negedge clk);
        end
        req = '0;
        repeat (15) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
